// File: rtl/yutorina_muldiv_pkg.sv
// Shared definitions for the iterative multiply/divide unit.
//   muldiv_op_e    : operation codes presented on the op port (code 3 reserved, runs as MUL)
//   muldiv_state_e : controller state encodings
//   MULDIV_CNT_W   : iteration counter width for the default 32-bit datapath
package yutorina_muldiv_pkg;

   localparam int MULDIV_CNT_W = 5;

   typedef enum logic [2:0] {
      OP_MUL   = 3'd0,
      OP_MULH  = 3'd1,
      OP_MULHU = 3'd2,
      OP_RSVD  = 3'd3,
      OP_DIV   = 3'd4,
      OP_DIVU  = 3'd5,
      OP_REM   = 3'd6,
      OP_REMU  = 3'd7
   } muldiv_op_e;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_CALC = 2'd1,
      ST_FIX  = 2'd2,
      ST_DONE = 2'd3
   } muldiv_state_e;

   // Operands of these ops are interpreted as two's complement.
   function automatic logic op_is_signed(input muldiv_op_e op);
      return (op == OP_MULH) || (op == OP_DIV) || (op == OP_REM);
   endfunction

endpackage

// File: rtl/yutorina_muldiv_step.sv
// One radix-2 iteration of the multiply/divide datapath (purely combinational).
//   is_div : 1 = restoring-divide step, 0 = shift-add multiply step
//   hi_i   : upper accumulator (partial product high / partial remainder)
//   lo_i   : lower accumulator (multiplier + product low / dividend + quotient)
//   b_i    : multiplicand or divisor magnitude
//   hi_o, lo_o : accumulators after this iteration
module yutorina_muldiv_step #(
   parameter int WIDTH = 32
) (
   input  logic             is_div,
   input  logic [WIDTH-1:0] hi_i,
   input  logic [WIDTH-1:0] lo_i,
   input  logic [WIDTH-1:0] b_i,
   output logic [WIDTH-1:0] hi_o,
   output logic [WIDTH-1:0] lo_o
);

   logic [WIDTH-1:0] addend;
   logic [WIDTH:0]   sum;
   logic [WIDTH:0]   shifted;
   logic [WIDTH:0]   diff;

   assign addend  = lo_i[0] ? b_i : {WIDTH{1'b0}};
   assign sum     = {1'b0, hi_i} + {1'b0, addend};
   assign shifted = {hi_i, lo_i[WIDTH-1]};
   // The partial remainder stays below the divisor, so a clear top bit of
   // diff means the subtraction did not borrow.
   assign diff    = shifted - {1'b0, b_i};

   always_comb begin
      hi_o = hi_i;
      lo_o = lo_i;
      if (is_div) begin
         if (!diff[WIDTH]) begin
            hi_o = diff[WIDTH-1:0];
            lo_o = {lo_i[WIDTH-2:0], 1'b1};
         end else begin
            hi_o = shifted[WIDTH-1:0];
            lo_o = {lo_i[WIDTH-2:0], 1'b0};
         end
      end else begin
         // Carry out of the add shifts into the high word.
         hi_o = sum[WIDTH:1];
         lo_o = {sum[0], lo_i[WIDTH-1:1]};
      end
   end

endmodule

// File: rtl/yutorina_muldiv.sv
// Iterative multiply/divide unit: MUL, MULH, MULHU, DIV, DIVU, REM, REMU,
// one result bit per clock, sign fix-up in a final cycle.
//   clk, reset     : clock, synchronous active-high reset
//   start, flush   : issue request (taken in IDLE/DONE), abort (wins over start)
//   op, lhs, rhs   : operation code and operands
//   busy, done,out : busy in CALC/FIX, one-cycle done pulse, registered result
// Optional build macro YUTORINA_MULDIV_EARLY_OUT_EN shortens CALC when the
// remaining work is trivial; results are unchanged.
//
// state | meaning
// IDLE  | waiting for start
// CALC  | one shift-add / restoring-subtract iteration per cycle
// FIX   | sign correction, result-half select, out registered
// DONE  | done pulse; a new start may be taken here
module yutorina_muldiv
   import yutorina_muldiv_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int CNT_W = MULDIV_CNT_W
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic             flush,
   input  logic [2:0]       op,
   input  logic [WIDTH-1:0] lhs,
   input  logic [WIDTH-1:0] rhs,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] out
);

   muldiv_state_e    state_q, state_d;
   muldiv_op_e       op_q, op_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d, b_q, b_d, out_q, out_d;
   logic             neg_q, neg_d;
`ifdef YUTORINA_MULDIV_EARLY_OUT_EN
   logic             early_q, early_d;
   logic             mul_rest_zero;
`endif

   muldiv_op_e       op_in;
   logic             l_neg, r_neg;
   logic [WIDTH-1:0] l_mag, r_mag, step_hi, step_lo, res;
   logic [2*WIDTH-1:0] prod;

   assign op_in = muldiv_op_e'(op);
   assign l_neg = op_is_signed(op_in) & lhs[WIDTH-1];
   assign r_neg = op_is_signed(op_in) & rhs[WIDTH-1];
   assign l_mag = l_neg ? -lhs : lhs;
   assign r_mag = r_neg ? -rhs : rhs;

   yutorina_muldiv_step #(.WIDTH(WIDTH)) u_step (
      .is_div (op_q[2]),
      .hi_i   (hi_q),
      .lo_i   (lo_q),
      .b_i    (b_q),
      .hi_o   (step_hi),
      .lo_o   (step_lo)
   );

`ifdef YUTORINA_MULDIV_EARLY_OUT_EN
   // Unconsumed multiplier bits sit in lo_q[WIDTH-1-cnt:0].
   assign mul_rest_zero = ((lo_q & ({WIDTH{1'b1}} >> cnt_q)) == {WIDTH{1'b0}});
`endif

   // Result formation used in FIX.
   always_comb begin
      prod = {hi_q, lo_q};
`ifdef YUTORINA_MULDIV_EARLY_OUT_EN
      // Early multiply exit skipped pure right shifts; apply them here.
      if (!op_q[2] && early_q) prod = prod >> (WIDTH - int'(cnt_q));
`endif
      if (neg_q) prod = -prod;
      res = prod[WIDTH-1:0];
      if (op_q[2]) begin
         res = op_q[1] ? hi_q : lo_q;
         if (neg_q) res = -res;
      end else if ((op_q == OP_MULH) || (op_q == OP_MULHU)) begin
         res = prod[2*WIDTH-1:WIDTH];
      end
   end

   always_comb begin
      state_d = state_q;
      op_d    = op_q;
      cnt_d   = cnt_q;
      hi_d    = hi_q;
      lo_d    = lo_q;
      b_d     = b_q;
      neg_d   = neg_q;
      out_d   = out_q;
`ifdef YUTORINA_MULDIV_EARLY_OUT_EN
      early_d = early_q;
`endif
      if (flush) begin
         state_d = ST_IDLE;
      end else begin
         unique case (state_q)
            ST_IDLE, ST_DONE: begin
               state_d = ST_IDLE;
               if (start) begin
                  state_d = ST_CALC;
                  op_d    = (op_in == OP_RSVD) ? OP_MUL : op_in;
                  cnt_d   = '0;
                  hi_d    = '0;
`ifdef YUTORINA_MULDIV_EARLY_OUT_EN
                  early_d = 1'b0;
`endif
                  if (op_in[2]) begin
                     lo_d  = l_mag;
                     b_d   = r_mag;
                     neg_d = op_in[1] ? l_neg : (l_neg ^ r_neg);
                     if (rhs == '0) begin
                        // Preloading remainder=lhs and quotient=all-ones lets
                        // FIX produce the divide-by-zero results unchanged.
                        state_d = ST_FIX;
                        hi_d    = lhs;
                        lo_d    = '1;
                        neg_d   = 1'b0;
                     end
`ifdef YUTORINA_MULDIV_EARLY_OUT_EN
                     else if (l_mag < r_mag) begin
                        state_d = ST_FIX;
                        hi_d    = l_mag;
                        lo_d    = '0;
                     end
`endif
                  end else begin
                     lo_d  = r_mag;
                     b_d   = l_mag;
                     neg_d = (op_in == OP_MULH) ? (l_neg ^ r_neg) : 1'b0;
                  end
               end
            end
            ST_CALC: begin
`ifdef YUTORINA_MULDIV_EARLY_OUT_EN
               if (!op_q[2] && mul_rest_zero) begin
                  state_d = ST_FIX;
                  early_d = 1'b1;
               end else
`endif
               begin
                  hi_d = step_hi;
                  lo_d = step_lo;
                  if (cnt_q == CNT_W'(WIDTH - 1)) state_d = ST_FIX;
                  else cnt_d = cnt_q + 1'b1;
               end
            end
            ST_FIX: begin
               out_d   = res;
               state_d = ST_DONE;
            end
            default: state_d = ST_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= ST_IDLE;
         op_q    <= OP_MUL;
         cnt_q   <= '0;
         hi_q    <= '0;
         lo_q    <= '0;
         b_q     <= '0;
         neg_q   <= 1'b0;
         out_q   <= '0;
`ifdef YUTORINA_MULDIV_EARLY_OUT_EN
         early_q <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         op_q    <= op_d;
         cnt_q   <= cnt_d;
         hi_q    <= hi_d;
         lo_q    <= lo_d;
         b_q     <= b_d;
         neg_q   <= neg_d;
         out_q   <= out_d;
`ifdef YUTORINA_MULDIV_EARLY_OUT_EN
         early_q <= early_d;
`endif
      end
   end

   assign busy = (state_q == ST_CALC) || (state_q == ST_FIX);
   assign done = (state_q == ST_DONE);
   assign out  = out_q;

endmodule

// File: tb/tb_yutorina_muldiv.sv
module tb_yutorina_muldiv;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        start = 1'b0;
   logic        flush = 1'b0;
   logic [2:0]  op = 3'd0;
   logic [31:0] lhs = '0;
   logic [31:0] rhs = '0;
   logic        busy, done;
   logic [31:0] out;

   int checks = 0;
   int failures = 0;
   logic [31:0] exp_q[$];

   yutorina_muldiv dut (
      .clk   (clk),
      .reset (reset),
      .start (start),
      .flush (flush),
      .op    (op),
      .lhs   (lhs),
      .rhs   (rhs),
      .busy  (busy),
      .done  (done),
      .out   (out)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [2:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] exp;
      int          lat;
   } vec_t;

   vec_t vecs[20];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   // Reference arithmetic using 64-bit integers.
   function automatic logic [31:0] model(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
      longint sa, sb, sp, sq;
      logic [63:0] up;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      case (o)
         3'd1: begin sp = sa * sb; up = 64'(sp); return up[63:32]; end
         3'd2: begin up = {32'd0, a} * {32'd0, b}; return up[63:32]; end
         3'd4: begin if (b == 0) return 32'hFFFF_FFFF; sq = sa / sb; return sq[31:0]; end
         3'd5: begin if (b == 0) return 32'hFFFF_FFFF; return a / b; end
         3'd6: begin if (b == 0) return a; sq = sa % sb; return sq[31:0]; end
         3'd7: begin if (b == 0) return a; return a % b; end
         default: return a * b;
      endcase
   endfunction

   // Drive one start pulse; returns #1 after the sampling edge.
   task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
      start = 1'b1;
      op    = o;
      lhs   = a;
      rhs   = b;
      @(posedge clk);
      #1;
      start = 1'b0;
   endtask

   // Wait (bounded) for done; lat counts edges from the start edge, busy_n counts busy samples.
   task automatic wait_done(output int lat, output int busy_n, output bit got);
      lat = 0;
      busy_n = busy ? 1 : 0;
      got = 1'b0;
      for (int i = 0; i < 100; i++) begin
         @(posedge clk);
         #1;
         lat++;
         if (busy) busy_n++;
         if (done) begin
            got = 1'b1;
            break;
         end
      end
   endtask

   task automatic finish_op(input string name, input int exp_lat, input bit chk_busy);
      int lat, busy_n;
      bit got;
      logic [31:0] e;
      wait_done(lat, busy_n, got);
      if (!got) begin
         checks++;
         failures++;
         $display("FAIL %s_timeout: no done within 100 cycles", name);
         void'(exp_q.pop_front());
         return;
      end
      check({name, "_latency"}, 32'(lat), 32'(exp_lat));
      if (chk_busy) check({name, "_busy_cycles"}, 32'(busy_n), 32'(exp_lat));
      if (exp_q.size() == 0) begin
         checks++;
         failures++;
         $display("FAIL %s_scoreboard: done with empty queue, got 0x%08h", name, out);
      end else begin
         e = exp_q.pop_front();
         check({name, "_out"}, out, e);
      end
   endtask

   initial begin
      int lat, busy_n, seen;
      bit got;
      logic [2:0] ro;
      logic [31:0] ra, rb;
      logic [31:0] prior;

      vecs[0]  = '{3'd0, 32'd7,         32'd6,         32'h0000_002A, 33};
      vecs[1]  = '{3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 33};
      vecs[2]  = '{3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 33};
      vecs[3]  = '{3'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 33};
      vecs[4]  = '{3'd4, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, 33};
      vecs[5]  = '{3'd6, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 33};
      vecs[6]  = '{3'd5, 32'hFFFF_FFF9, 32'd2,         32'h7FFF_FFFC, 33};
      vecs[7]  = '{3'd5, 32'd5,         32'd0,         32'hFFFF_FFFF, 1};
      vecs[8]  = '{3'd6, 32'd5,         32'd0,         32'h0000_0005, 1};
      vecs[9]  = '{3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 33};
      vecs[10] = '{3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 33};
      vecs[11] = '{3'd1, 32'h8000_0000, 32'd2,         32'hFFFF_FFFF, 33};
      vecs[12] = '{3'd3, 32'd3,         32'd5,         32'h0000_000F, 33};
      vecs[13] = '{3'd7, 32'd100,       32'd7,         32'h0000_0002, 33};
      vecs[14] = '{3'd4, 32'd7,         32'hFFFF_FFFE, 32'hFFFF_FFFD, 33};
      vecs[15] = '{3'd6, 32'd7,         32'hFFFF_FFFE, 32'h0000_0001, 33};
      vecs[16] = '{3'd2, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 33};
      vecs[17] = '{3'd4, 32'd0,         32'd5,         32'h0000_0000, 33};
      vecs[18] = '{3'd4, 32'hFFFF_FFF8, 32'd0,         32'hFFFF_FFFF, 1};
      vecs[19] = '{3'd6, 32'hFFFF_FFF8, 32'd0,         32'hFFFF_FFF8, 1};

      repeat (3) @(posedge clk);
      #1;
      reset = 1'b0;
      check("reset_busy", 32'(busy), 32'd0);
      check("reset_done", 32'(done), 32'd0);
      check("reset_out", out, 32'd0);

      foreach (vecs[i]) begin
         issue(vecs[i].op, vecs[i].a, vecs[i].b);
         exp_q.push_back(vecs[i].exp);
         finish_op($sformatf("vec%0d", i), vecs[i].lat, 1'b1);
      end

      for (int i = 0; i < 16; i++) begin
         ro = 3'($urandom_range(0, 6));
         if (ro == 3'd3) ro = 3'd7;
         ra = $urandom;
         rb = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom;
         if (i == 3) rb = 32'd0;
         issue(ro, ra, rb);
         exp_q.push_back(model(ro, ra, rb));
         finish_op($sformatf("rand%0d", i), (ro[2] && rb == 0) ? 1 : 33, 1'b0);
      end

      // start while busy is ignored
      issue(3'd0, 32'd7, 32'd6);
      exp_q.push_back(32'h2A);
      repeat (5) begin @(posedge clk); #1; end
      issue(3'd5, 32'd100, 32'd10);
      finish_op("start_while_busy", 27, 1'b0);
      @(posedge clk);
      #1;
      check("ignored_start_no_busy", 32'(busy), 32'd0);

      // back-to-back: second start accepted in the DONE cycle
      issue(3'd0, 32'd3, 32'd4);
      exp_q.push_back(32'd12);
      finish_op("b2b_first", 33, 1'b0);
      issue(3'd4, 32'd100, 32'hFFFF_FFFB);
      exp_q.push_back(32'hFFFF_FFEC);
      finish_op("b2b_second", 33, 1'b1);

      // flush mid-operation
      prior = 32'hFFFF_FFEC;
      issue(3'd0, 32'd7, 32'd6);
      repeat (9) begin @(posedge clk); #1; end
      check("flush_busy_before", 32'(busy), 32'd1);
      flush = 1'b1;
      @(posedge clk);
      #1;
      flush = 1'b0;
      check("flush_busy_drop", 32'(busy), 32'd0);
      seen = 0;
      for (int i = 0; i < 40; i++) begin
         @(posedge clk);
         #1;
         if (done || busy) seen++;
      end
      check("flush_no_activity", 32'(seen), 32'd0);
      check("flush_out_kept", out, prior);

      // start and flush together: nothing begins
      flush = 1'b1;
      issue(3'd0, 32'd1, 32'd1);
      flush = 1'b0;
      seen = 0;
      for (int i = 0; i < 40; i++) begin
         if (done || busy) seen++;
         @(posedge clk);
         #1;
      end
      check("start_flush_dropped", 32'(seen), 32'd0);
      check("start_flush_out_kept", out, prior);

      // reset during an operation
      issue(3'd0, 32'd7, 32'd6);
      repeat (4) begin @(posedge clk); #1; end
      reset = 1'b1;
      @(posedge clk);
      #1;
      reset = 1'b0;
      check("midop_reset_busy", 32'(busy), 32'd0);
      check("midop_reset_done", 32'(done), 32'd0);
      check("midop_reset_out", out, 32'd0);

      issue(3'd0, 32'd9, 32'd9);
      exp_q.push_back(32'd81);
      finish_op("after_reset", 33, 1'b1);

      check("scoreboard_empty", 32'(exp_q.size()), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
